// File: rtl/rtc_seg_scan.sv
// Six-digit multiplexed 7-segment scanner for a BCD real-time clock.
// Define RTC_LZ_BLANK_EN to blank a leading zero in the tens-of-hours slot.
module rtc_seg_scan #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hrm,
    input  logic [3:0] hrl,
    input  logic [3:0] minm,
    input  logic [3:0] minl,
    input  logic [3:0] secm,
    input  logic [3:0] secl,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       frame_start
);
    localparam int unsigned    PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [23:0]   r_snap;

    logic          w_guard;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    // Snapshot loads on the same edge that wraps idx, so a frame always shows one time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            if (r_idx == 3'd5) begin
                r_idx  <= '0;
                r_snap <= {hrm, hrl, minm, minl, secm, secl};
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            localparam logic [PW-1:0] GUARD_W = PW'(GUARD);
            assign w_guard = (r_pre < GUARD_W);
        end
    endgenerate

    always_comb begin
        w_digit = '0;
        case (r_idx)
            3'd0:    w_digit = r_snap[3:0];
            3'd1:    w_digit = r_snap[7:4];
            3'd2:    w_digit = r_snap[11:8];
            3'd3:    w_digit = r_snap[15:12];
            3'd4:    w_digit = r_snap[19:16];
            3'd5:    w_digit = r_snap[23:20];
            default: w_digit = '0;
        endcase
    end

    always_comb begin
        w_seg = 7'h40;
        case (w_digit)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h40;
        endcase
`ifdef RTC_LZ_BLANK_EN
        if ((r_idx == 3'd5) && (w_digit == 4'd0)) begin
            w_seg = '0;
        end
`endif
    end

    assign seg         = w_seg;
    assign an          = w_guard ? '1 : ~(6'b000001 << r_idx);
    assign dp          = !w_guard && ((r_idx == 3'd2) || (r_idx == 3'd4));
    assign frame_start = (r_idx == 3'd0) && (r_pre == '0);

endmodule

// File: tb/tb_rtc_seg_scan.sv
// Scoreboard bench for rtc_seg_scan (SCAN_DIV=4, GUARD=1); honours RTC_LZ_BLANK_EN.
module tb_rtc_seg_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hrm, hrl, minm, minl, secm, secl;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       frame_start;

    rtc_seg_scan #(.SCAN_DIV(4), .GUARD(1)) dut (
        .clk(clk), .rst(rst),
        .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl), .secm(secm), .secl(secl),
        .seg(seg), .an(an), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

`ifdef RTC_LZ_BLANK_EN
    localparam logic [6:0] Z5 = 7'h00;
`else
    localparam logic [6:0] Z5 = 7'h3F;
`endif

    typedef struct {
        int         cyc;
        int         frame;
        int         slot;
        int         pre;
        logic [6:0] seg;
        logic [5:0] an;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   last_fs = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the display presents a value every cycle; compare whatever is due now
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_fs = -1;
        end else if (frame_start) begin
            if (last_fs >= 0) begin
                n_total++;
                if (cyc - last_fs == 24) n_pass++;
                else $display("FAIL fs_period: got %0d cycles, want 24", cyc - last_fs);
            end
            last_fs = cyc;
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_total++;
            if (e.cyc == cyc && seg == e.seg && an == e.an && dp == e.dp && frame_start == e.fs)
                n_pass++;
            else
                $display("FAIL frame%0d_slot%0d_pre%0d: got seg=%h an=%b dp=%b fs=%b, want seg=%h an=%b dp=%b fs=%b (cyc %0d/%0d)",
                         e.frame, e.slot, e.pre, seg, an, dp, frame_start,
                         e.seg, e.an, e.dp, e.fs, cyc, e.cyc);
        end
    end

    function automatic logic [5:0] an_on(input int s);
        case (s)
            0:       return 6'b111110;
            1:       return 6'b111101;
            2:       return 6'b111011;
            3:       return 6'b110111;
            4:       return 6'b101111;
            default: return 6'b011111;
        endcase
    endfunction

    function automatic logic [41:0] fv(input logic [6:0] s0, s1, s2, s3, s4, s5);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int fr, input int s, input int p, input logic [6:0] sg);
        exp_t e;
        e.cyc   = cyc;
        e.frame = fr;
        e.slot  = s;
        e.pre   = p;
        e.seg   = sg;
        e.an    = (p == 0) ? 6'b111111 : an_on(s);
        e.dp    = (p != 0) && (s == 2 || s == 4);
        e.fs    = (s == 0) && (p == 0);
        q.push_back(e);
    endtask

    task automatic do_slot(input int fr, input int s, input logic [6:0] sg, input int npre);
        for (int p = 0; p < npre; p++) begin
            push_exp(fr, s, p, sg);
            if (p < npre - 1 || npre == 4) tick();
        end
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hrm = a; hrl = b; minm = c; minl = d; secm = e; secl = f;
    endtask

    initial begin
        logic [41:0] fz, f1, f2, f3, f4;
        fz = fv(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, Z5);
        f1 = fv(7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
        f2 = fv(7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
        f3 = fv(7'h40, 7'h6D, 7'h66, 7'h4F, 7'h5B, Z5);
        f4 = fv(7'h40, 7'h3F, 7'h6F, 7'h7F, 7'h5B, Z5);

        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Frame 0 shows the cleared snapshot; inputs 12:34:56 load at its end
        for (int s = 0; s < 6; s++) do_slot(0, s, fz[7*s +: 7], 4);

        // Frame 1: secl changes mid-frame and must not show until frame 2
        for (int s = 0; s < 6; s++) begin
            if (s == 2) secl = 4'd7;
            do_slot(1, s, f1[7*s +: 7], 4);
        end

        // Frame 2: invalid BCD and a zero tens-of-hours digit queued for frame 3
        for (int s = 0; s < 6; s++) begin
            if (s == 0) begin
                secl = 4'hB;
                hrm  = 4'd0;
            end
            do_slot(2, s, f2[7*s +: 7], 4);
        end

        for (int s = 0; s < 6; s++) begin
            if (s == 1) begin
                minl = 4'd9;
                minm = 4'd8;
                secm = 4'd0;
            end
            do_slot(3, s, f3[7*s +: 7], 4);
        end

        for (int s = 0; s < 6; s++) do_slot(4, s, f4[7*s +: 7], 4);

        // Frame 5: reset lands at idx=3, pre=2
        for (int s = 0; s < 3; s++) do_slot(5, s, f4[7*s +: 7], 4);
        do_slot(5, 3, f4[21 +: 7], 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int s = 0; s < 6; s++) do_slot(6, s, fz[7*s +: 7], 4);
        for (int s = 0; s < 6; s++) do_slot(7, s, f4[7*s +: 7], 4);

        tick();
        tick();
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rtc_seg_scan.md
RTC_SEG_SCAN -- requirements
Module: rtc_seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per digit slot; legal range 2..65535.
REQ-002 Parameter GUARD, default 16: anode-off cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hrm, hrl, minm, minl, secm, secl  input  4 each  BCD time digits from the RTC counter.
REQ-006 seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-007 an  output  6  digit anodes, active-low, one-hot when a slot is lit; an[k] selects slot k.
REQ-008 dp  output  1  decimal point, active-high.
REQ-009 frame_start  output  1  one-cycle pulse in the first cycle of slot 0.

Function
REQ-010 The prescaler pre SHALL count 0..SCAN_DIV-1 and wrap to 0; the slot index idx SHALL advance only when pre==SCAN_DIV-1.
REQ-011 The slot index SHALL run 0,1,2,3,4,5 and then wrap to 0; slot map: 0=secl, 1=secm, 2=minl, 3=minm, 4=hrl, 5=hrm.
REQ-012 A 24-bit snapshot register SHALL load all six inputs when idx==5 and pre==SCAN_DIV-1, in the same edge that idx wraps to 0.
REQ-013 Every displayed digit SHALL come from the snapshot and never from the live inputs, so one frame never mixes two RTC times.
REQ-014 seg, an, dp and frame_start SHALL be decoded combinationally from the registered idx, pre and snapshot (zero latency from state).
REQ-015 Decode (hex, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; values 10..15 SHALL show 40 ('-').
REQ-016 When pre<GUARD, an SHALL be 6'b111111; otherwise an SHALL equal ~(1<<idx).
REQ-017 dp SHALL be 1 in slots 2 and 4 while the anode is active, and 0 otherwise.
REQ-018 frame_start SHALL be 1 exactly when idx==0 and pre==0.
REQ-019 An input change in the middle of a frame SHALL NOT affect the display until the next snapshot load.

Reset
REQ-020 While rst is high at a clock edge, pre, idx and the snapshot SHALL be cleared to 0.
REQ-021 In the first cycle after reset: seg=3F, dp=0 and frame_start=1; an=111111 if GUARD>0, else 111110.
REQ-022 The first frame after reset SHALL display 00.00.00.
REQ-023 A reset asserted mid-frame SHALL abort the frame immediately, with no partial snapshot load.

Configuration
REQ-024 The macro RTC_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-025 With RTC_LZ_BLANK_EN defined: in slot 5, a snapshot hrm of 0 SHALL drive seg=00 while the anode is still active (blanked leading zero).
REQ-026 Without RTC_LZ_BLANK_EN: slot 5 SHALL decode hrm like every other slot (0 shows 3F).

Verification (SCAN_DIV=4, GUARD=1)
REQ-027 Release reset with inputs 12:34:56 -> frame 0 shows 00.00.00; frame 1 shows slot0 seg=7D (6), slot5 seg=06 (1); dp=1 only in slots 2 and 4.
REQ-028 Count cycles between frame_start pulses -> exactly 24 cycles; an=111111 in cycle 0 of each slot, then the one-hot low anode for 3 cycles.
REQ-029 Change inputs from 12:34:56 to 12:34:57 while idx=2 -> the rest of the frame is unchanged; slot 0 of the next frame shows 07.
REQ-030 Drive secl=4'hB -> slot 0 shows seg=40.
REQ-031 Assert rst for one cycle while idx=3, pre=2 -> next cycle idx=0, pre=0, frame_start=1, snapshot=0.
REQ-032 With hrm=0: with RTC_LZ_BLANK_EN defined, slot 5 seg=00 and an=011111 after the guard cycle; without the macro, slot 5 seg=3F.
